// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM duty-cycle capture block.
package pwm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_LEVEL_W = 8;
  localparam int DEF_TIMEOUT = 65535;

endpackage

// File: rtl/pwm_div_seq.sv
// Sequential restoring divider: (num << LEVEL_W) / den, one quotient bit per cycle,
// result clamped to LEVEL_W bits. done is asserted during the final iteration cycle.
module pwm_div_seq #(
  parameter int CNT_W   = 16,
  parameter int LEVEL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   num,
  input  logic [CNT_W-1:0]   den,
  output logic               busy,
  output logic               done,
  output logic [LEVEL_W-1:0] quotient
);

  localparam int STEP_W = $clog2(LEVEL_W + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(LEVEL_W);

  logic               busy_reg;
  logic [STEP_W-1:0]  step_reg;
  logic [CNT_W-1:0]   rem_reg;
  logic [CNT_W-1:0]   den_reg;
  logic [LEVEL_W:0]   bits_reg;
  logic [LEVEL_W-1:0] quo_reg;

  logic [CNT_W:0]     trial;
  logic               ge;
  logic [CNT_W-1:0]   rem_next;
  logic [LEVEL_W:0]   quo_full;

  // Since num <= den, the quotient never exceeds 2^LEVEL_W, so the remainder can
  // start from num >> 1 and only the low LEVEL_W+1 numerator bits need shifting in.
  always_comb begin
    trial    = {rem_reg, bits_reg[LEVEL_W]};
    ge       = (trial >= {1'b0, den_reg});
    rem_next = ge ? CNT_W'(trial - {1'b0, den_reg}) : CNT_W'(trial);
    quo_full = {quo_reg, ge};
  end

  assign busy     = busy_reg;
  assign done     = busy_reg && (step_reg == LAST_STEP);
  assign quotient = quo_full[LEVEL_W] ? {LEVEL_W{1'b1}} : quo_full[LEVEL_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= 1'b0;
      step_reg <= '0;
      rem_reg  <= '0;
      den_reg  <= '0;
      bits_reg <= '0;
      quo_reg  <= '0;
    end else if (abort) begin
      busy_reg <= 1'b0;
    end else if (busy_reg) begin
      rem_reg  <= rem_next;
      bits_reg <= bits_reg << 1;
      quo_reg  <= quo_full[LEVEL_W-1:0];
      step_reg <= step_reg + STEP_W'(1);
      if (step_reg == LAST_STEP) begin
        busy_reg <= 1'b0;
      end
    end else if (start) begin
      busy_reg <= 1'b1;
      step_reg <= '0;
      rem_reg  <= {1'b0, num[CNT_W-1:1]};
      bits_reg <= {num[0], {LEVEL_W{1'b0}}};
      den_reg  <= den;
      quo_reg  <= '0;
    end
  end

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures period and high time of an external PWM input between rising edges and
// converts the duty cycle to a brightness code; flags a stuck input after TIMEOUT cycles.
module pwm_duty_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwm_in,
  output logic [CNT_W-1:0]   period_o,
  output logic [CNT_W-1:0]   high_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               valid_o,
  output logic               stuck_o,
  output logic               overrun_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

  logic               sync_reg;
  logic               s_q_reg;
  logic               s_d_reg;
  logic               rise;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   per_cnt_reg, per_cnt_next;
  logic [CNT_W-1:0]   hi_cnt_reg, hi_cnt_next;
  logic               hold_reg, hold_next;

  logic               capture;
  logic               timeout_hit;
  logic               div_start;
  logic               div_busy;
  logic               div_done;
  logic [LEVEL_W-1:0] div_q;
  logic [CNT_W-1:0]   cap_per_reg;
  logic [CNT_W-1:0]   cap_hi_reg;

  logic [CNT_W-1:0]   period_reg;
  logic [CNT_W-1:0]   high_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic               valid_reg;
  logic               stuck_reg;
  logic               overrun_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 1'b0;
      s_q_reg  <= 1'b0;
      s_d_reg  <= 1'b0;
    end else begin
      sync_reg <= pwm_in;
      s_q_reg  <= sync_reg;
      s_d_reg  <= s_q_reg;
    end
  end

  assign rise = s_q_reg & ~s_d_reg;

  // A rise in the same cycle the count reaches TIMEOUT takes precedence; hold_reg
  // keeps a stuck input from re-triggering until the next rise.
  assign timeout_hit = (per_cnt_reg == TIMEOUT_CNT) && !hold_reg && !rise;
  assign capture     = (state_reg == MEASURE) && rise;
  assign div_start   = capture && !div_busy;

  always_comb begin
    state_next   = state_reg;
    per_cnt_next = per_cnt_reg;
    hi_cnt_next  = hi_cnt_reg;
    hold_next    = hold_reg;
    if (rise) begin
      state_next   = MEASURE;
      per_cnt_next = ONE_CNT;
      hi_cnt_next  = ONE_CNT;
      hold_next    = 1'b0;
    end else if (timeout_hit) begin
      state_next = IDLE;
      hold_next  = 1'b1;
    end else if (!hold_reg) begin
      per_cnt_next = per_cnt_reg + ONE_CNT;
      if (state_reg == MEASURE) begin
        hi_cnt_next = hi_cnt_reg + CNT_W'(s_q_reg);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
      hold_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      per_cnt_reg <= per_cnt_next;
      hi_cnt_reg  <= hi_cnt_next;
      hold_reg    <= hold_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_per_reg <= '0;
      cap_hi_reg  <= '0;
    end else if (div_start) begin
      cap_per_reg <= per_cnt_reg;
      cap_hi_reg  <= hi_cnt_reg;
    end
  end

  pwm_div_seq #(
    .CNT_W   (CNT_W),
    .LEVEL_W (LEVEL_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (timeout_hit),
    .num      (hi_cnt_reg),
    .den      (per_cnt_reg),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_reg  <= '0;
      high_reg    <= '0;
      level_reg   <= '0;
      valid_reg   <= 1'b0;
      stuck_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      valid_reg   <= 1'b0;
      overrun_reg <= capture && div_busy;
      if (timeout_hit) begin
        period_reg <= '0;
        high_reg   <= '0;
        level_reg  <= {LEVEL_W{s_q_reg}};
        stuck_reg  <= 1'b1;
        valid_reg  <= 1'b1;
      end else if (div_done) begin
        period_reg <= cap_per_reg;
        high_reg   <= cap_hi_reg;
        level_reg  <= div_q;
        stuck_reg  <= 1'b0;
        valid_reg  <= 1'b1;
      end
    end
  end

  assign period_o  = period_reg;
  assign high_o    = high_reg;
  assign level_o   = level_reg;
  assign valid_o   = valid_reg;
  assign stuck_o   = stuck_reg;
  assign overrun_o = overrun_reg;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture: table of PWM shapes plus stuck, reset and overrun sequences.
module tb_pwm_duty_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [15:0] period_o;
  logic [15:0] high_o;
  logic [7:0]  level_o;
  logic        valid_o;
  logic        stuck_o;
  logic        overrun_o;

  pwm_duty_capture #(
    .CNT_W   (16),
    .LEVEL_W (8),
    .TIMEOUT (1000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .period_o  (period_o),
    .high_o    (high_o),
    .level_o   (level_o),
    .valid_o   (valid_o),
    .stuck_o   (stuck_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int high;
    int exp_level;
  } vec_t;

  vec_t vecs [8];

  int total = 0;
  int bad = 0;
  int tick = 0;
  int last_rise_tick = 0;
  int vcount = 0;
  int ocount = 0;
  int last_per = 0;
  int last_hi = 0;
  int last_lvl = 0;
  int last_stuck = 0;
  int last_lat = 0;
  bit check_each = 1'b0;
  int each_per = 0;
  int each_hi = 0;
  int each_lvl = 0;
  int v0 = 0;
  int o0 = 0;

  task automatic chk(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Samples outputs at the falling edge, then drives the next pwm_in value.
  task automatic step(input logic v);
    @(negedge clk);
    tick++;
    if (overrun_o) ocount++;
    if (valid_o) begin
      vcount++;
      last_per   = int'(period_o);
      last_hi    = int'(high_o);
      last_lvl   = int'(level_o);
      last_stuck = int'(stuck_o);
      last_lat   = tick - last_rise_tick;
      $display("valid @%0d: period=%0d high=%0d level=%0d stuck=%0d", tick, last_per, last_hi, last_lvl, last_stuck);
      if (check_each) begin
        chk("each_period", last_per, each_per);
        chk("each_high", last_hi, each_hi);
        chk("each_level", last_lvl, each_lvl);
      end
    end
    if (v && !pwm_in) last_rise_tick = tick;
    pwm_in = v;
  endtask

  task automatic run_pwm(input int period, input int high, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < period; i++) begin
        step(i < high);
      end
    end
  endtask

  initial begin
    vecs[0] = '{256, 64, 64};
    vecs[1] = '{300, 100, 85};
    vecs[2] = '{200, 199, 254};
    vecs[3] = '{20, 10, 128};
    vecs[4] = '{10, 1, 25};
    vecs[5] = '{10, 9, 230};
    vecs[6] = '{100, 99, 253};
    vecs[7] = '{1000, 500, 128};

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("rst_period", int'(period_o), 0);
    chk("rst_high", int'(high_o), 0);
    chk("rst_level", int'(level_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_stuck", int'(stuck_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);
    rst = 1'b0;

    // Table of steady PWM shapes; first capture after reset needs two rises
    for (int k = 0; k < 8; k++) begin
      v0 = vcount;
      o0 = ocount;
      run_pwm(vecs[k].period, vecs[k].high, 4);
      $display("vector %0d: period=%0d high=%0d -> level=%0d", k, vecs[k].period, vecs[k].high, last_lvl);
      chk("vec_valids", int'(vcount - v0 >= 2), 1);
      chk("vec_period", last_per, vecs[k].period);
      chk("vec_high", last_hi, vecs[k].high);
      chk("vec_level", last_lvl, vecs[k].exp_level);
      chk("vec_stuck", last_stuck, 0);
      chk("vec_overrun", ocount - o0, 0);
      if (vecs[k].period > 12) chk("vec_latency", last_lat, 12);
    end

    // Input stuck high after PWM
    run_pwm(256, 64, 2);
    v0 = vcount;
    for (int i = 0; i < 1100; i++) step(1'b1);
    chk("stuck1_valids", vcount - v0, 2);
    chk("stuck1_flag", last_stuck, 1);
    chk("stuck1_level", last_lvl, 255);
    chk("stuck1_period", last_per, 0);
    chk("stuck1_high", last_hi, 0);
    chk("stuck1_latency", int'(last_lat >= 1002 && last_lat <= 1003), 1);

    // Input stuck low after PWM
    run_pwm(256, 64, 2);
    v0 = vcount;
    for (int i = 0; i < 1100; i++) step(1'b0);
    chk("stuck0_valids", vcount - v0, 1);
    chk("stuck0_flag", last_stuck, 1);
    chk("stuck0_level", last_lvl, 0);
    chk("stuck0_period", last_per, 0);

    // Period shorter than the divide time: every other capture dropped
    v0 = vcount;
    o0 = ocount;
    each_per = 5;
    each_hi = 2;
    each_lvl = 102;
    check_each = 1'b1;
    run_pwm(5, 2, 40);
    check_each = 1'b0;
    chk("short_valids", vcount - v0, 19);
    chk("short_overruns", ocount - o0, 19);

    // Resume normal PWM clears stuck
    run_pwm(300, 100, 3);
    chk("resume_stuck", last_stuck, 0);
    chk("resume_period", last_per, 300);
    chk("resume_high", last_hi, 100);
    chk("resume_level", last_lvl, 85);

    // Reset in the middle of a divide
    step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_period", int'(period_o), 0);
    chk("midrst_high", int'(high_o), 0);
    chk("midrst_level", int'(level_o), 0);
    chk("midrst_valid", int'(valid_o), 0);
    for (int i = 0; i < 3; i++) step(1'b0);
    rst = 1'b0;
    v0 = vcount;
    for (int i = 0; i < 50; i++) step(1'b0);
    chk("midrst_no_valid", vcount - v0, 0);

    // After reset, one rise alone produces nothing; the second gives a capture
    run_pwm(256, 64, 1);
    chk("rst_one_rise", vcount - v0, 0);
    step(1'b1);
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("rst_two_rises", vcount - v0, 1);
    chk("rst_two_period", last_per, 256);
    chk("rst_two_level", last_lvl, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
